// File: rtl/fxp_seq_divider.sv
// Sequential sign-magnitude fixed-point divider (restoring, BPC quotient bits per clock).
// Reports divide-by-zero and overflow with saturation; results hold until the next done.
module fxp_seq_divider #(
  parameter int N   = 32,
  parameter int Q   = 16,
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic         dz,
  output logic         ovf
);

  localparam int W     = N - 1 + Q;
  localparam int ITERS = (W + BPC - 1) / BPC;
  localparam int DW    = ITERS * BPC;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [N-1:0]    r_rem, w_rem_nxt;
  logic [DW-1:0]   r_dvd, w_dvd_nxt;
  logic [DW-1:0]   r_quo, w_quo_nxt;
  logic [N-2:0]    r_bmag, w_bmag_nxt;
  logic            r_sign, w_sign_nxt;
  logic            r_asign, w_asign_nxt;
  logic            r_zero, w_zero_nxt;
  logic [N-1:0]    r_q, w_q_nxt;
  logic            r_dz, w_dz_nxt;
  logic            r_ovf, w_ovf_nxt;

  logic            w_accept;
  logic [N-1:0]    w_rem_step;
  logic [DW-1:0]   w_dvd_step;
  logic [DW-1:0]   w_quo_step;
  logic [N:0]      w_trial;
  logic [DW-1:0]   w_dvd_init;

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign q    = r_q;
  assign dz   = r_dz;
  assign ovf  = r_ovf;

  // Dividend is |a| followed by Q zero fraction bits, left-padded to a whole number of steps.
  assign w_dvd_init = DW'({a[N-2:0], {Q{1'b0}}});
  assign w_accept   = start && (r_state != S_RUN);

  // BPC restoring steps: shift in the next dividend bit, keep the trial difference if non-negative.
  always_comb begin
    w_rem_step = r_rem;
    w_dvd_step = r_dvd;
    w_quo_step = r_quo;
    w_trial    = '0;
    for (int i = 0; i < BPC; i++) begin
      w_rem_step = {w_rem_step[N-2:0], w_dvd_step[DW-1]};
      w_dvd_step = {w_dvd_step[DW-2:0], 1'b0};
      w_trial    = {1'b0, w_rem_step} - {2'b00, r_bmag};
      if (!w_trial[N]) begin
        w_rem_step = w_trial[N-1:0];
        w_quo_step = {w_quo_step[DW-2:0], 1'b1};
      end else begin
        w_quo_step = {w_quo_step[DW-2:0], 1'b0};
      end
    end
  end

  // Next-state and datapath/result next values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rem_nxt   = r_rem;
    w_dvd_nxt   = r_dvd;
    w_quo_nxt   = r_quo;
    w_bmag_nxt  = r_bmag;
    w_sign_nxt  = r_sign;
    w_asign_nxt = r_asign;
    w_zero_nxt  = r_zero;
    w_q_nxt     = r_q;
    w_dz_nxt    = r_dz;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = CW'(ITERS);
          w_rem_nxt   = '0;
          w_dvd_nxt   = w_dvd_init;
          w_quo_nxt   = '0;
          w_bmag_nxt  = b[N-2:0];
          w_sign_nxt  = a[N-1] ^ b[N-1];
          w_asign_nxt = a[N-1];
          w_zero_nxt  = (b[N-2:0] == '0);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_zero) begin
          w_state_nxt = S_DONE;
          w_q_nxt     = {r_asign, {(N-1){1'b1}}};
          w_dz_nxt    = 1'b1;
          w_ovf_nxt   = 1'b0;
        end else begin
          w_rem_nxt = w_rem_step;
          w_dvd_nxt = w_dvd_step;
          w_quo_nxt = w_quo_step;
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = S_DONE;
            w_dz_nxt    = 1'b0;
            // Any quotient bit above the magnitude field means the result cannot be represented.
            if (|w_quo_step[DW-1:N-1]) begin
              w_q_nxt   = {r_sign, {(N-1){1'b1}}};
              w_ovf_nxt = 1'b1;
            end else if (w_quo_step[N-2:0] == '0) begin
              w_q_nxt   = '0;
              w_ovf_nxt = 1'b0;
            end else begin
              w_q_nxt   = {r_sign, w_quo_step[N-2:0]};
              w_ovf_nxt = 1'b0;
            end
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_bmag  <= '0;
      r_sign  <= 1'b0;
      r_asign <= 1'b0;
      r_zero  <= 1'b0;
      r_q     <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_rem   <= w_rem_nxt;
      r_dvd   <= w_dvd_nxt;
      r_quo   <= w_quo_nxt;
      r_bmag  <= w_bmag_nxt;
      r_sign  <= w_sign_nxt;
      r_asign <= w_asign_nxt;
      r_zero  <= w_zero_nxt;
      r_q     <= w_q_nxt;
      r_dz    <= w_dz_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_fxp_seq_divider.sv
// Directed and randomized bench for fxp_seq_divider in BPC=1, 2 and 4 configurations.
// Index 0/1/2 of the vectors below selects the BPC=1/2/4 instance.
module tb_fxp_seq_divider;

  localparam int TO = 200;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  dz_v;
  logic [2:0]  ovf_v;
  logic [31:0] q_v [3];

  int checks   = 0;
  int failures = 0;

  fxp_seq_divider #(.N(32), .Q(16), .BPC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .q(q_v[0]), .dz(dz_v[0]), .ovf(ovf_v[0]));
  fxp_seq_divider #(.N(32), .Q(16), .BPC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .q(q_v[1]), .dz(dz_v[1]), .ovf(ovf_v[1]));
  fxp_seq_divider #(.N(32), .Q(16), .BPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .q(q_v[2]), .dz(dz_v[2]), .ovf(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {dz, ovf, q} computed with plain integer division.
  function automatic logic [33:0] ref_div(input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] num, den, qf;
    logic [30:0] mag;
    logic        s;
    num = {33'd0, av[30:0]} << 16;
    den = {33'd0, bv[30:0]};
    if (den == 64'd0) return {1'b1, 1'b0, av[31], 31'h7FFFFFFF};
    qf = num / den;
    if (qf > 64'h7FFFFFFF) return {1'b0, 1'b1, av[31] ^ bv[31], 31'h7FFFFFFF};
    mag = qf[30:0];
    s = (mag == 31'd0) ? 1'b0 : (av[31] ^ bv[31]);
    return {1'b0, 1'b0, s, mag};
  endfunction

  // Accept one op on instance d; returns at the negedge where done is seen.
  // lat = edges from the accepting edge to the done edge; bsy = cycles busy was seen.
  task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bsy, output bit to);
    @(negedge clk);
    a = av; b = bv; start_v[d] = 1'b1;
    @(posedge clk);
    #1 start_v[d] = 1'b0;
    lat = -1; bsy = 0; to = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      if (done_v[d]) begin
        lat = i - 1; to = 1'b0;
        break;
      end
      if (busy_v[d]) bsy++;
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({busy_v[d], done_v[d], dz_v[d], ovf_v[d], q_v[d]} !== 36'd0) begin
        failures++;
        $display("FAIL reset_state inst=%0d got busy=%b done=%b dz=%b ovf=%b q=%h want all 0",
                 d, busy_v[d], done_v[d], dz_v[d], ovf_v[d], q_v[d]);
      end
    end
  endtask

  task automatic test_exact;
    int lat, bsy; bit to;
    run_op(0, 32'h00060000, 32'h00020000, lat, bsy, to);
    checks++;
    if (to || lat != 47) begin failures++; $display("FAIL exact_latency got %0d want 47", lat); end
    checks++;
    if (bsy != 47) begin failures++; $display("FAIL exact_busy_cycles got %0d want 47", bsy); end
    checks++;
    if ({q_v[0], dz_v[0], ovf_v[0]} !== {32'h00030000, 2'b00}) begin
      failures++; $display("FAIL exact_result got q=%h dz=%b ovf=%b want q=00030000 dz=0 ovf=0", q_v[0], dz_v[0], ovf_v[0]);
    end
    @(negedge clk);
    checks++;
    if (done_v[0] !== 1'b0) begin failures++; $display("FAIL exact_done_pulse got done=%b want 0", done_v[0]); end
  endtask

  task automatic test_trunc;
    int lat, bsy; bit to;
    run_op(0, 32'h80010000, 32'h00030000, lat, bsy, to);
    checks++;
    if (to || q_v[0] !== 32'h80005555) begin failures++; $display("FAIL trunc_neg got q=%h want 80005555", q_v[0]); end
    run_op(0, 32'h00000000, 32'h80020000, lat, bsy, to);
    checks++;
    if (to || {q_v[0], dz_v[0]} !== {32'h00000000, 1'b0}) begin
      failures++; $display("FAIL trunc_zero got q=%h dz=%b want q=00000000 dz=0", q_v[0], dz_v[0]);
    end
  endtask

  task automatic test_dz;
    int lat, bsy; bit to;
    run_op(0, 32'h80050000, 32'h80000000, lat, bsy, to);
    checks++;
    if (to || lat != 1) begin failures++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++;
    if ({q_v[0], dz_v[0], ovf_v[0]} !== {32'hFFFFFFFF, 2'b10}) begin
      failures++; $display("FAIL dz_result got q=%h dz=%b ovf=%b want q=ffffffff dz=1 ovf=0", q_v[0], dz_v[0], ovf_v[0]);
    end
  endtask

  task automatic test_ovf;
    int lat, bsy; bit to, moved;
    run_op(0, 32'h4E200000, 32'h00008000, lat, bsy, to);
    checks++;
    if (to || {q_v[0], dz_v[0], ovf_v[0]} !== {32'h7FFFFFFF, 2'b01}) begin
      failures++; $display("FAIL ovf_result got q=%h dz=%b ovf=%b want q=7fffffff dz=0 ovf=1", q_v[0], dz_v[0], ovf_v[0]);
    end
    moved = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if ({q_v[0], dz_v[0], ovf_v[0]} !== {32'h7FFFFFFF, 2'b01}) moved = 1'b1;
    end
    // Start a new op and confirm results still hold while it runs.
    a = 32'h00060000; b = 32'h00020000; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if ({q_v[0], dz_v[0], ovf_v[0]} !== {32'h7FFFFFFF, 2'b01}) moved = 1'b1;
    end
    checks++;
    if (moved) begin failures++; $display("FAIL ovf_hold got q=%h ovf=%b want held 7fffffff/1", q_v[0], ovf_v[0]); end
    to = 1'b1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      if (done_v[0]) begin to = 1'b0; break; end
    end
    checks++;
    if (to || {q_v[0], ovf_v[0]} !== {32'h00030000, 1'b0}) begin
      failures++; $display("FAIL ovf_next_result got q=%h ovf=%b want 00030000/0", q_v[0], ovf_v[0]);
    end
  endtask

  task automatic test_ignore_start;
    int e, lat; bit extra;
    @(negedge clk);
    a = 32'h00060000; b = 32'h00020000; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    e = 0;
    repeat (10) begin @(negedge clk); e++; end
    a = 32'h00010000; b = 32'h00010000; start_v[0] = 1'b1;
    @(negedge clk); e++;
    start_v[0] = 1'b0;
    lat = -1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk); e++;
      if (done_v[0]) begin lat = e - 1; break; end
    end
    checks++;
    if (lat != 47 || q_v[0] !== 32'h00030000) begin
      failures++; $display("FAIL ignore_start got lat=%0d q=%h want lat=47 q=00030000", lat, q_v[0]);
    end
    extra = 1'b0;
    repeat (60) begin @(negedge clk); if (done_v[0]) extra = 1'b1; end
    checks++;
    if (extra) begin failures++; $display("FAIL ignore_extra_done got extra done want none"); end
  endtask

  task automatic test_back_to_back;
    int lat, bsy; bit to;
    run_op(0, 32'h00060000, 32'h00020000, lat, bsy, to);
    a = 32'h00010000; b = 32'h00020000; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_v[0], done_v[0]} !== 2'b10) begin
      failures++; $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy_v[0], done_v[0]);
    end
    lat = -1;
    for (int i = 2; i <= TO; i++) begin
      @(negedge clk);
      if (done_v[0]) begin lat = i - 1; break; end
    end
    checks++;
    if (lat != 47 || q_v[0] !== 32'h00008000) begin
      failures++; $display("FAIL b2b_result got lat=%0d q=%h want lat=47 q=00008000", lat, q_v[0]);
    end
  endtask

  task automatic test_bpc;
    int lat, bsy; bit to;
    run_op(2, 32'h00078000, 32'h80028000, lat, bsy, to);
    checks++;
    if (to || lat != 12 || q_v[2] !== 32'h80030000) begin
      failures++; $display("FAIL bpc4 got lat=%0d q=%h want lat=12 q=80030000", lat, q_v[2]);
    end
    run_op(1, 32'h00060000, 32'h00020000, lat, bsy, to);
    checks++;
    if (to || lat != 24 || q_v[1] !== 32'h00030000) begin
      failures++; $display("FAIL bpc2 got lat=%0d q=%h want lat=24 q=00030000", lat, q_v[1]);
    end
  endtask

  task automatic test_reset_midrun;
    bit seen;
    @(negedge clk);
    a = 32'h00070000; b = 32'h00020000; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_v[0], done_v[0], dz_v[0], ovf_v[0], q_v[0]} !== 36'd0) begin
      failures++; $display("FAIL reset_midrun got busy=%b done=%b dz=%b ovf=%b q=%h want all 0",
                           busy_v[0], done_v[0], dz_v[0], ovf_v[0], q_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin @(negedge clk); if (done_v[0] || busy_v[0]) seen = 1'b1; end
    checks++;
    if (seen) begin failures++; $display("FAIL reset_abort got activity after reset want none"); end
  endtask

  task automatic test_random;
    int lat, bsy, exp_lat; bit to;
    logic [31:0] av, bv;
    logic [33:0] exp_v;
    int iters [3] = '{47, 24, 12};
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 20; k++) begin
        av = $urandom >> $urandom_range(0, 16);
        av[31] = 1'($urandom_range(0, 1));
        bv = $urandom >> $urandom_range(0, 31);
        bv[31] = 1'($urandom_range(0, 1));
        if (k % 7 == 3) bv[30:0] = 31'd0;
        exp_v = ref_div(av, bv);
        exp_lat = exp_v[33] ? 1 : iters[d];
        run_op(d, av, bv, lat, bsy, to);
        checks++;
        if (to || lat != exp_lat || {dz_v[d], ovf_v[d], q_v[d]} !== exp_v) begin
          failures++;
          $display("FAIL random inst=%0d a=%h b=%h got lat=%0d dz=%b ovf=%b q=%h want lat=%0d dz=%b ovf=%b q=%h",
                   d, av, bv, lat, dz_v[d], ovf_v[d], q_v[d], exp_lat, exp_v[33], exp_v[32], exp_v[31:0]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start_v = 3'b000; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_exact;
    test_trunc;
    test_dz;
    test_ovf;
    test_ignore_start;
    test_back_to_back;
    test_bpc;
    test_reset_midrun;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
